// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-stage access controller.
// Holds the controller FSM state encoding, the load-lane select constants and
// the alignment helper used when MEM_ACCESS_MISALIGN_CHECK_EN is defined.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Alignment test for an incoming access.
    // Load width comes from the core's shared funct3 encoding:
    // LB=000, LH=001, LW=010, LBU=100, LHU=101.
    // Any unlisted code is a word access, because it is serviced as LW.
    // A store is classified by its byte mask.
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [2:0] funct3,
                                           input logic [3:0] wmask,
                                           input logic [1:0] offset);
        logic half_acc;
        logic word_acc;
        if (is_load) begin
            half_acc = (funct3 == 3'b001) || (funct3 == 3'b101);
            word_acc = !half_acc && (funct3 != 3'b000) && (funct3 != 3'b100);
        end else begin
            half_acc = (wmask == 4'b0011) || (wmask == 4'b1100);
            word_acc = (wmask == 4'b1111);
        end
        return (half_acc && offset[0]) || (word_acc && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extract.sv
// load_extract: combinational lane select plus sign/zero extension of a
// returned memory word, for the load width in funct3 and the low address bits.
module load_extract
    import mem_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane out of the word.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            LANE_B0: w_byte = i_word[7:0];
            LANE_B1: w_byte = i_word[15:8];
            LANE_B2: w_byte = i_word[23:16];
            LANE_B3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    // Pick the addressed halfword. Only bit 1 matters, so an odd offset
    // rounds down to its containing halfword.
    always_comb begin
        w_half = i_word[15:0];
        if (i_offset[1] == HALF_HI) begin
            w_half = i_word[31:16];
        end
    end

    // Extend by load type. LB=000 and LH=001 sign-extend.
    // LBU=100 and LHU=101 zero-extend.
    // LW=010 and every unused code pass the whole word through.
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            3'b000:  o_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  o_data = {{16{w_half[15]}}, w_half};
            3'b100:  o_data = {24'd0, w_byte};
            3'b101:  o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller for the three-stage core.
// The controller does three things:
// - It takes one load or store from execute.
// - It issues that access on a valid/ready memory port and stalls the
//   pipeline while the access is outstanding.
// - It returns extended load data to writeback as a one-cycle pulse.
// Optional build macro: MEM_ACCESS_MISALIGN_CHECK_EN. When it is defined,
// misaligned halfword and word accesses are dropped and flagged on the
// 'misaligned' port. Without it, the port is absent.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    input  logic              x_is_load,
    input  logic [3:0]        x_wmask,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    input  logic [2:0]        x_funct3,
    input  logic [4:0]        x_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [3:0]        mem_req_wmask,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    ,
    output logic              misaligned
`endif
);

    mem_state_e        r_state;
    mem_state_e        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wmask;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic              r_is_load;

    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_accept;
    logic              w_issue;
    logic              w_resp_take;
    logic [DATA_W-1:0] w_load_data;

    // Any execute-stage memory op is taken only while the controller is idle.
    // Inputs seen while stalled are ignored.
    assign w_accept = (r_state == ST_IDLE) && x_valid && (x_is_load || (x_wmask != 4'b0000));

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_misaligned;

    assign w_misalign = is_misaligned(x_is_load, x_funct3, x_wmask, x_addr[1:0]);
    assign w_issue    = w_accept && !w_misalign;
    assign misaligned = r_misaligned;

    // Flag a dropped misaligned access for exactly the cycle after it was seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_misalign;
        end
    end
`else
    assign w_issue = w_accept;
`endif

    // A response counts only in WAIT. A response that arrives with the
    // request handshake, or while idle, is ignored.
    assign w_resp_take = (r_state == ST_WAIT) && mem_resp_valid;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the state-derived handshake/stall outputs.
    // A store retires on the request handshake. A load waits for its data.
    always_comb begin
        w_next_state  = r_state;
        mem_req_valid = 1'b0;
        stall         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                stall = 1'b0;
                if (w_issue) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = r_is_load ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                stall        = 1'b0;
            end
        endcase
    end

    // Capture the request when it is accepted, then hold it unchanged until
    // the next accept so that the fields stay stable while ready is low.
    // A load never writes, so any mask that comes with it is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_wmask   <= 4'b0000;
            r_wdata   <= '0;
            r_funct3  <= 3'b000;
            r_rd      <= 5'd0;
            r_is_load <= 1'b0;
        end else if (w_issue) begin
            r_addr    <= x_addr;
            r_wmask   <= x_is_load ? 4'b0000 : x_wmask;
            r_wdata   <= x_wdata;
            r_funct3  <= x_funct3;
            r_rd      <= x_rd;
            r_is_load <= x_is_load;
        end
    end

    assign mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_req_wmask = r_wmask;
    assign mem_req_wdata = r_wdata;

    load_extract u_load_extract (
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .i_word   (mem_resp_data),
        .o_data   (w_load_data)
    );

    // Register the extended load result. wb_valid pulses for one cycle, and
    // the destination and data hold until the next load completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_resp_take;
            if (w_resp_take) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for the memory-stage access controller.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each step compares the DUT against hand-computed values.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        x_valid;
   logic        x_is_load;
   logic [3:0]  x_wmask;
   logic [31:0] x_addr;
   logic [31:0] x_wdata;
   logic [2:0]  x_funct3;
   logic [4:0]  x_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [3:0]  mem_req_wmask;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   logic        misaligned;
`endif

   int testsRun  = 0;
   int failCount = 0;
   int reqCount  = 0;
   int wbCount   = 0;
   int reqStart;
   int wbStart;
   int stallCycles;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .x_valid        (x_valid),
      .x_is_load      (x_is_load),
      .x_wmask        (x_wmask),
      .x_addr         (x_addr),
      .x_wdata        (x_wdata),
      .x_funct3       (x_funct3),
      .x_rd           (x_rd),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wmask  (mem_req_wmask),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .stall          (stall),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data)
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      ,
      .misaligned     (misaligned)
`endif
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Count request handshakes and writeback pulses as the clock samples them.
   always @(posedge clk) begin
      if (mem_req_valid && mem_req_ready) reqCount <= reqCount + 1;
      if (wb_valid) wbCount <= wbCount + 1;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic v, input logic ld, input logic [3:0] m,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3, input logic [4:0] rd);
      x_valid   = v;
      x_is_load = ld;
      x_wmask   = m;
      x_addr    = a;
      x_wdata   = d;
      x_funct3  = f3;
      x_rd      = rd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Zero-wait load: the request is accepted at once and the response
   // arrives in the first WAIT cycle.
   task automatic runLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [3:0] mask, input logic [4:0] rd,
                          input logic [31:0] word, input logic [31:0] expData);
      applyStimulus(1'b1, 1'b1, mask, addr, 32'hFFFF_FFFF, f3, rd);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput({tag, ".reqValid"}, mem_req_valid, 1);
      checkOutput({tag, ".reqAddr"}, mem_req_addr, {addr[31:2], 2'b00});
      checkOutput({tag, ".reqWmask"}, mem_req_wmask, 0);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = word;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput({tag, ".wbValid"}, wb_valid, 1);
      checkOutput({tag, ".wbRd"}, wb_rd, rd);
      checkOutput({tag, ".wbData"}, wb_data, expData);
      checkOutput({tag, ".stall"}, stall, 0);
   endtask

   initial begin
      reset          = 1'b1;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);

      // Reset state.
      tick();
      checkOutput("rst.reqValid", mem_req_valid, 0);
      checkOutput("rst.reqAddr", mem_req_addr, 0);
      checkOutput("rst.reqWmask", mem_req_wmask, 0);
      checkOutput("rst.reqWdata", mem_req_wdata, 0);
      checkOutput("rst.stall", stall, 0);
      checkOutput("rst.wbValid", wb_valid, 0);
      checkOutput("rst.wbRd", wb_rd, 0);
      checkOutput("rst.wbData", wb_data, 0);
      reset = 1'b0;
      tick();

      // Byte store with ready high: one request cycle, no writeback.
      applyStimulus(1'b1, 1'b0, 4'b0100, 32'h0000_1002, 32'h00AB_0000, 3'b000, 5'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_7000, 32'h0, 3'b010, 5'd3);
      checkOutput("sb.reqValid", mem_req_valid, 1);
      checkOutput("sb.reqAddr", mem_req_addr, 32'h0000_1000);
      checkOutput("sb.reqWmask", mem_req_wmask, 4'b0100);
      checkOutput("sb.reqWdata", mem_req_wdata, 32'h00AB_0000);
      checkOutput("sb.stall", stall, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput("sb.stallEnd", stall, 0);
      checkOutput("sb.reqDone", mem_req_valid, 0);
      checkOutput("sb.noWb", wb_valid, 0);
      tick();
      checkOutput("sb.stalledOpIgnored", stall, 0);

      // LB with the response two cycles after the handshake.
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_2003, 32'h0, 3'b000, 5'd5);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput("lb.reqValid", mem_req_valid, 1);
      checkOutput("lb.reqAddr", mem_req_addr, 32'h0000_2000);
      checkOutput("lb.reqWmask", mem_req_wmask, 0);
      tick();
      checkOutput("lb.waitStall", stall, 1);
      checkOutput("lb.waitReqLow", mem_req_valid, 0);
      tick();
      checkOutput("lb.stillWait", stall, 1);
      checkOutput("lb.noEarlyWb", wb_valid, 0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h8012_3456;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("lb.wbValid", wb_valid, 1);
      checkOutput("lb.wbRd", wb_rd, 5);
      checkOutput("lb.wbData", wb_data, 32'hFFFF_FF80);
      checkOutput("lb.stallEnd", stall, 0);
      tick();
      checkOutput("lb.wbPulse", wb_valid, 0);
      checkOutput("lb.wbHold", wb_data, 32'hFFFF_FF80);

      // Zero-extending and pass-through loads. The LBU also carries a stray mask.
      runLoad("lbu", 32'h0000_2003, 3'b100, 4'b1111, 5'd7, 32'h8012_3456, 32'h0000_0080);
      runLoad("lhu", 32'h0000_2000, 3'b101, 4'b0000, 5'd8, 32'h1234_ABCD, 32'h0000_ABCD);
      runLoad("lwAlt", 32'h0000_6000, 3'b111, 4'b0000, 5'd12, 32'h89AB_CDEF, 32'h89AB_CDEF);
      tick();

      // LH with ready held low for three cycles. A response that arrives with
      // the handshake must be ignored.
      stallCycles = 0;
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_2002, 32'h0, 3'b001, 5'd6);
      mem_req_ready = 1'b0;
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      for (int i = 0; i < 3; i++) begin
         if (stall) stallCycles++;
         checkOutput("lh.holdValid", mem_req_valid, 1);
         checkOutput("lh.holdAddr", mem_req_addr, 32'h0000_2000);
         checkOutput("lh.holdWmask", mem_req_wmask, 0);
         tick();
      end
      if (stall) stallCycles++;
      checkOutput("lh.hsValid", mem_req_valid, 1);
      checkOutput("lh.hsAddr", mem_req_addr, 32'h0000_2000);
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_0000;
      tick();
      if (stall) stallCycles++;
      checkOutput("lh.hsRespIgnored", wb_valid, 0);
      mem_resp_data = 32'h8001_7FFF;
      tick();
      mem_resp_valid = 1'b0;
      if (stall) stallCycles++;
      checkOutput("lh.wbValid", wb_valid, 1);
      checkOutput("lh.wbRd", wb_rd, 6);
      checkOutput("lh.wbData", wb_data, 32'hFFFF_8001);
      checkOutput("lh.stallCycles", stallCycles, 5);
      tick();

      // Reset while waiting for a load response.
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_4000, 32'h5A5A_5A5A, 3'b010, 5'd9);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      tick();
      checkOutput("rw.inWait", stall, 1);
      reset = 1'b1;
      #1;
      checkOutput("rw.reqValid", mem_req_valid, 0);
      checkOutput("rw.reqAddr", mem_req_addr, 0);
      checkOutput("rw.reqWdata", mem_req_wdata, 0);
      checkOutput("rw.stall", stall, 0);
      checkOutput("rw.wbRd", wb_rd, 0);
      checkOutput("rw.wbData", wb_data, 0);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1234_5678;
      tick();
      reset = 1'b0;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("rw.noWbAfter", wb_valid, 0);
      checkOutput("rw.idle", stall, 0);
      tick();
      checkOutput("rw.noWbLater", wb_valid, 0);
      checkOutput("rw.wbDataZero", wb_data, 0);

      // Stray response in IDLE, then back-to-back LW, SW and LW.
      reqStart = reqCount;
      wbStart  = wbCount;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_BEEF;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("b2b.strayIgnored", wb_valid, 0);
      checkOutput("b2b.strayNoStall", stall, 0);
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_5000, 32'h0, 3'b010, 5'd10);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput("b2b.lw1Addr", mem_req_addr, 32'h0000_5000);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1122_3344;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("b2b.lw1Wb", wb_valid, 1);
      checkOutput("b2b.lw1Rd", wb_rd, 10);
      checkOutput("b2b.lw1Data", wb_data, 32'h1122_3344);
      applyStimulus(1'b1, 1'b0, 4'b1111, 32'h0000_5004, 32'hCAFE_F00D, 3'b010, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput("b2b.swValid", mem_req_valid, 1);
      checkOutput("b2b.swAddr", mem_req_addr, 32'h0000_5004);
      checkOutput("b2b.swWmask", mem_req_wmask, 4'b1111);
      checkOutput("b2b.swWdata", mem_req_wdata, 32'hCAFE_F00D);
      checkOutput("b2b.swNoWb", wb_valid, 0);
      tick();
      checkOutput("b2b.swDone", stall, 0);
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_5008, 32'h0, 3'b010, 5'd11);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput("b2b.lw2Addr", mem_req_addr, 32'h0000_5008);
      checkOutput("b2b.lw2Wmask", mem_req_wmask, 0);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5566_7788;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("b2b.lw2Wb", wb_valid, 1);
      checkOutput("b2b.lw2Rd", wb_rd, 11);
      checkOutput("b2b.lw2Data", wb_data, 32'h5566_7788);
      tick();
      checkOutput("b2b.reqCount", reqCount - reqStart, 3);
      checkOutput("b2b.wbCount", wbCount - wbStart, 2);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      // Misaligned word load is dropped and flagged.
      applyStimulus(1'b1, 1'b1, 4'h0, 32'h0000_3001, 32'h0, 3'b010, 5'd4);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000, 5'd0);
      checkOutput("mis.flag", misaligned, 1);
      checkOutput("mis.noReq", mem_req_valid, 0);
      checkOutput("mis.noStall", stall, 0);
      tick();
      checkOutput("mis.pulse", misaligned, 0);
      checkOutput("mis.stillIdle", stall, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
